// File: rtl/bcd_countdown_pkg.sv
// Shared definitions for the two-digit BCD down-counter: FSM state encoding,
// the largest legal BCD digit, and a nibble validity helper.
package bcd_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd_byte(input logic [7:0] val);
    return (val[7:4] <= BCD_MAX) && (val[3:0] <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer; wraps 0 to 9 and raises borrow so digits can be chained.
module bcd_digit_dec
  import bcd_countdown_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       en,
  output logic [3:0] next_digit,
  output logic       borrow
);

  assign borrow = en && (digit == 4'd0);

  always_comb begin
    next_digit = digit;
    if (en) begin
      next_digit = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// Two-digit BCD down-counter (00-99) with load, start/pause control, a tick
// prescaler, and registered busy/done/err outputs for seven-segment driving.
module bcd_countdown
  import bcd_countdown_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t          state, state_nx;
  logic [3:0]      tens_nx, ones_nx;
  logic [PW-1:0]   presc, presc_nx;
  logic            busy_nx, done_nx, err_nx;
  logic            tick, load_ok, at_one, at_zero;
  logic [3:0]      ones_dec, tens_dec;
  logic            ones_borrow, tens_borrow;

  assign tick    = (state == ST_RUN) && (presc == PRESC_LAST);
  assign load_ok = is_bcd_byte(load_val);
  assign at_one  = (tens == 4'd0) && (ones == 4'd1);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);

  bcd_digit_dec u_ones_dec (
    .digit      (ones),
    .en         (tick),
    .next_digit (ones_dec),
    .borrow     (ones_borrow)
  );

  bcd_digit_dec u_tens_dec (
    .digit      (tens),
    .en         (ones_borrow),
    .next_digit (tens_dec),
    .borrow     (tens_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tens  <= 4'd0;
      ones  <= 4'd0;
      presc <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      tens  <= tens_nx;
      ones  <= ones_nx;
      presc <= presc_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

  // A rejected load consumes the cycle: nothing else advances while it is asserted.
  always_comb begin
    state_nx = state;
    tens_nx  = tens;
    ones_nx  = ones;
    presc_nx = presc;
    if (load) begin
      if (load_ok) begin
        state_nx = ST_IDLE;
        tens_nx  = load_val[7:4];
        ones_nx  = load_val[3:0];
        presc_nx = '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state_nx = at_zero ? ST_DONE : ST_RUN;
            presc_nx = '0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_nx = ST_PAUSED;
          end else if (tick) begin
            presc_nx = '0;
            if (!tens_borrow) begin
              tens_nx = tens_dec;
              ones_nx = ones_dec;
            end
            if (at_one || at_zero) begin
              state_nx = ST_DONE;
            end
          end else begin
            presc_nx = presc + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (start) begin
            state_nx = ST_RUN;
          end
        end
        ST_DONE: ;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_nx = (state_nx == ST_RUN) || (state_nx == ST_PAUSED);
    done_nx = (state_nx == ST_DONE) && (state != ST_DONE);
    err_nx  = load && !load_ok;
  end

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown with TICK_DIV=4: a vector
// table for load/start/pause handling plus hand-written timing sequences.
module tb_bcd_countdown;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [3:0] exp_tens;
    logic [3:0] exp_ones;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[15];

  bcd_countdown #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tens     (tens),
    .ones     (ones),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] et, input logic [3:0] eo,
                             input logic eb, input logic ed, input logic ee);
    checks++;
    if ({tens, ones, busy, done, err} !== {et, eo, eb, ed, ee}) begin
      failures++;
      $display("[TB] FAIL %s: got tens=%0d ones=%0d busy=%b done=%b err=%b, want tens=%0d ones=%0d busy=%b done=%b err=%b",
               name, tens, ones, busy, done, err, et, eo, eb, ed, ee);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then release all requests.
  task automatic applyStimulus(input logic ld, input logic [7:0] val, input logic st, input logic ps);
    load = ld; load_val = val; start = st; pause = ps;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulseReset(input string name);
    rst = 1'b1;
    #2;
    checkOutput(name, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput({name, "_after"}, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
    #2;
    checkOutput("reset_async", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset_state", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    //            load val    st    ps    tens  ones  busy  done  err
    vecs[0]  = '{1'b1, 8'h1A, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h37, 1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h9F, 1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h45, 1'b0, 1'b0, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0};

    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].load, vecs[v].load_val, vecs[v].start, vecs[v].pause);
      checkOutput($sformatf("vec%0d", v), vecs[v].exp_tens, vecs[v].exp_ones,
                  vecs[v].exp_busy, vecs[v].exp_done, vecs[v].exp_err);
    end

    // Full countdown from 12: one step every 4 edges, done on edge 48 only.
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("cnt12_k0", 4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      int val;
      @(posedge clk); #1;
      val = 12 - k / 4;
      checkOutput($sformatf("cnt12_k%0d", k), 4'(val / 10), 4'(val % 10),
                  (k < 48), (k == 48), 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("cnt12_hold%0d", k), 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("done_start_ignored", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Borrow across the tens digit.
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("borrow_pre", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("borrow_09", 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    idleCycles(4);
    checkOutput("borrow_08", 4'd0, 4'd8, 1'b1, 1'b0, 1'b0);
    pulseReset("reset_run");

    // Pause with the prescaler frozen at 2, then resume.
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(6);
    checkOutput("pause_pre", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idleCycles(20);
    checkOutput("pause_hold", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("pause_again", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("resume_0", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("resume_1", 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("resume_03", 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("pause_03", 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    pulseReset("reset_paused");

    // Mid-run reload returns to IDLE and restarts with a full prescale delay.
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(8);
    checkOutput("reload_07", 4'd0, 4'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
    checkOutput("reload_30", 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("reload_wait", 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("reload_29", 4'd2, 4'd9, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
Two-digit BCD down-counter Moore FSM (00–99). Loaded with a start value, it counts down once per prescaled tick and holds at 00 until reset or reload. It is the counting-down counterpart to the team's mod-10 up-counter that holds at 9. Outputs drive seven-segment decoders directly and give a one-cycle completion pulse to downstream control logic.

Parameters:
TICK_DIV, 4, clock cycles per count step (≥1); prescaler width = clog2(TICK_DIV), minimum 1 bit.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  load request; samples load_val
load_val  input  8  BCD start value, [7:4] tens, [3:0] ones
start  input  1  begin counting (from IDLE) or resume (from PAUSED)
pause  input  1  suspend counting while in RUN
tens  output  4  current tens digit (BCD)
ones  output  4  current ones digit (BCD)
busy  output  1  high in RUN or PAUSED
done  output  1  one-cycle pulse when count reaches 00 or a start occurs at 00
err  output  1  one-cycle pulse on rejected (non-BCD) load

Behaviour:
- Reset (async, immediate): state=IDLE, tens=0, ones=0, prescaler=0, busy=0, done=0, err=0.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
- Priority each cycle: load > start/pause > tick.
- load with valid BCD (both nibbles ≤9), accepted in any state:
  - value stored next edge;
  - state→IDLE, prescaler=0;
  - a simultaneous start/pause is ignored.
- load with either nibble >9: value and state unchanged; err=1 for the next cycle only.
- IDLE + start:
  - value≠00 → RUN, prescaler=0;
  - value=00 → DONE, done=1 next cycle.
- RUN:
  - prescaler increments each cycle and wraps at TICK_DIV-1;
  - a tick occurs on the edge where prescaler==TICK_DIV-1.
  - First decrement is visible TICK_DIV edges after the edge that sampled start.
- Decrement:
  - ones>0 → ones-1;
  - ones==0 → ones=9, tens-1 (borrow).
- Decrement from 01 to 00: state→DONE on the same edge; done=1 during the first cycle showing 00.
- RUN + pause (no load) → PAUSED; the pending tick on that edge is suppressed; prescaler frozen.
- PAUSED + start → RUN; prescaler resumes from its frozen value. pause while PAUSED is ignored.
- start while RUN or DONE: ignored. pause outside RUN: ignored.
- DONE: holds 00, busy=0, until load or reset. done never re-asserts in DONE.
- busy=1 exactly when state is RUN or PAUSED.
- Digits never leave 0–9. No wrap below 00.
- Reset during RUN or PAUSED aborts immediately to reset values; no done pulse.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSED=2'd2, ST_DONE=2'd3;
  - BCD_MAX=4'd9.
- One sub-module: bcd_digit_dec, a single-digit BCD decrementer.
  - Inputs: digit, en.
  - Outputs: next digit, borrow (borrow when digit==0 && en).
  - Instantiated twice and chained ones→tens.

Test Plan:
- rst pulsed mid-cycle (async) → tens/ones=0, busy=0, done=0, err=0 before the next clk edge.
- TICK_DIV=4, load 0x12 then start:
  - digits step 12,11,…,01,00, one step every 4 cycles;
  - done=1 for exactly 1 cycle, 48 cycles after start;
  - then holds 00 with busy=0.
- load 0x10, start, wait 4 cycles → display 09 (borrow); next tick → 08.
- load 0x05, start:
  - pause after 6 cycles (display 04), hold 20 cycles → display stays 04, busy=1;
  - start → 03 appears 2 cycles later (prescaler resumed from 2).
- load 0x1A → err=1 one cycle, value unchanged. Then load 0x00 + start → done=1 next cycle, state DONE.
- Mid-run load 0x30 while RUN at 07 → display 30, busy=0 (IDLE); start resumes from 30 with a full TICK_DIV delay.
